sequence_generator: RTL and testbench

//  Enumerates every gate sequence of length 1..HIGHEST_SEQ_INDEX+1 over gates 0..HIGHEST_GATE.

---
 rtl/sequence_generator_pkg.sv | 25 ++
 rtl/sequence_generator_if.sv | 27 ++
 rtl/sequence_generator_gate_odometer.sv | 61 ++++++
 rtl/sequence_generator.sv | 106 ++++++++++
 tb/tb_sequence_generator.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sequence_generator_pkg.sv
// Shared sizing and state encoding for the gate-sequence enumerator.
// Consumed by the generator, its odometer and the handshake interface.
package sequence_generator_pkg;

    localparam int SEQ_INDEX_BITS    = 2;
    localparam int HIGHEST_SEQ_INDEX = 1;
    localparam int HIGHEST_GATE      = 2;
    localparam int GATE_BITS         = 5;
    localparam int NUM_DIGITS        = HIGHEST_SEQ_INDEX + 1;

    // One bit wider than a digit so digit+1 cannot wrap before the limit compare.
    localparam logic [GATE_BITS:0] GATE_LIMIT = (GATE_BITS+1)'(HIGHEST_GATE);

    typedef logic [SEQ_INDEX_BITS-1:0] seq_index_t;
    typedef logic [GATE_BITS-1:0]      gate_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sequence_generator_if.sv
// Item handshake between the sequence generator and the sequence multiplier.
// master = generator side, slave = multiplier/controller side.
interface sequence_generator_if;
    import sequence_generator_pkg::*;

    logic       start;
    logic       halt;
    logic       available;
    seq_index_t seq_index;
    gate_t      seq_gate;
    logic       ready;
    logic       first;
    seq_index_t seq_length;
    logic       busy;
    logic       finished;

    modport master (
        input  start, halt, available,
        output seq_index, seq_gate, ready, first, seq_length, busy, finished
    );

    modport slave (
        output start, halt, available,
        input  seq_index, seq_gate, ready, first, seq_length, busy, finished
    );

endinterface

// File: rtl/sequence_generator_gate_odometer.sv
// Base-(HIGHEST_GATE+1) odometer holding one gate digit per sequence index.
// Reports the digit at sel_i plus, for a pending increment, the highest digit touched and the carry out of digit len_i.
module gate_odometer
    import sequence_generator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    input  seq_index_t len_i,
    input  seq_index_t sel_i,
    output gate_t      digit_o,
    output seq_index_t highest_changed_o,
    output logic       carry_out_o
);

    logic [NUM_DIGITS-1:0][GATE_BITS-1:0] digit_vec;
    logic [NUM_DIGITS:0]                  carry_in;
    logic [NUM_DIGITS-1:0]                wrap;
    logic [NUM_DIGITS-1:0]                in_len;

    assign carry_in[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            gate_t digit_q;

            assign in_len[gi]      = (gi <= int'(len_i));
            assign wrap[gi]        = (({1'b0, digit_q} + 1'b1) > GATE_LIMIT);
            // Digits above the current length never move, so the carry chain stops there.
            assign carry_in[gi+1]  = carry_in[gi] & wrap[gi] & in_len[gi];
            assign digit_vec[gi]   = digit_q;

            always_ff @(posedge clk) begin
                if (reset || clr_i) begin
                    digit_q <= '0;
                end else if (inc_i && carry_in[gi] && in_len[gi]) begin
                    digit_q <= wrap[gi] ? '0 : digit_q + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        digit_o           = '0;
        highest_changed_o = '0;
        carry_out_o       = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == int'(sel_i)) begin
                digit_o = digit_vec[i];
            end
            if (carry_in[i] && in_len[i]) begin
                highest_changed_o = seq_index_t'(i);
            end
            if (i == int'(len_i)) begin
                carry_out_o = carry_in[i+1];
            end
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Enumerates all gate sequences, shortest first, issuing only the digits that changed since the previous sequence.
// One item per ISSUE/WAIT pair; the multiplier paces the walk through `available`.
module sequence_generator
    import sequence_generator_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    sequence_generator_if.master seq_bus
);

    state_t     state_q, state_d;
    seq_index_t cur_q, cur_d;
    seq_index_t len_q, len_d;

    logic       odo_inc;
    logic       odo_clr;
    gate_t      digit_sel;
    seq_index_t top_idx;
    logic       odo_carry;

    gate_odometer u_odometer (
        .clk               (clk),
        .reset             (reset),
        .inc_i             (odo_inc),
        .clr_i             (odo_clr),
        .len_i             (len_q),
        .sel_i             (cur_q),
        .digit_o           (digit_sel),
        .highest_changed_o (top_idx),
        .carry_out_o       (odo_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        len_d   = len_q;
        odo_inc = 1'b0;
        odo_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (seq_bus.start) begin
                    state_d = ST_ISSUE;
                    cur_d   = '0;
                    len_d   = '0;
                    odo_clr = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (seq_bus.available) begin
                    if (cur_q != '0) begin
                        cur_d   = cur_q - 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end
            end
            ST_ADVANCE: begin
                // Halt only lands here, so a partially issued sequence is always completed first.
                if (seq_bus.halt) begin
                    state_d = ST_IDLE;
                end else if (odo_carry) begin
                    odo_clr = 1'b1;
                    if (int'(len_q) == HIGHEST_SEQ_INDEX) begin
                        state_d = ST_DONE;
                    end else begin
                        len_d   = len_q + 1'b1;
                        cur_d   = len_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    odo_inc = 1'b1;
                    cur_d   = top_idx;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign seq_bus.ready      = (state_q == ST_ISSUE);
    assign seq_bus.first      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (cur_q == len_q);
    assign seq_bus.seq_index  = cur_q;
    assign seq_bus.seq_gate   = digit_sel;
    assign seq_bus.seq_length = len_q;
    assign seq_bus.busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_ADVANCE);
    assign seq_bus.finished   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Randomised responder bench for sequence_generator, checked against an arithmetic enumeration of all gate sequences.
module tb_sequence_generator;
    import sequence_generator_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sequence_generator_if bus();

    sequence_generator dut (
        .clk     (clk),
        .reset   (reset),
        .seq_bus (bus)
    );

    typedef struct {
        int idx;
        int gate;
        int first;
        int len;
    } item_t;

    item_t model_q[$];
    int    checks_total  = 0;
    int    checks_passed = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks_total++;
        if (obs == exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int digit_of(input int n, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p *= (HIGHEST_GATE + 1);
        return (n / p) % (HIGHEST_GATE + 1);
    endfunction

    // Every length L counts n = 0 .. base**L-1; a sequence re-issues from its highest digit that differs from n-1.
    function automatic void build_model();
        item_t it;
        model_q.delete();
        for (int l = 1; l <= HIGHEST_SEQ_INDEX + 1; l++) begin
            int total = 1;
            for (int k = 0; k < l; k++) total *= (HIGHEST_GATE + 1);
            for (int n = 0; n < total; n++) begin
                int top = 0;
                if (n == 0) top = l - 1;
                else for (int i = 0; i < l; i++) if (digit_of(n, i) != digit_of(n - 1, i)) top = i;
                for (int i = top; i >= 0; i--) begin
                    it.idx   = i;
                    it.gate  = digit_of(n, i);
                    it.first = (i == l - 1) ? 1 : 0;
                    it.len   = l - 1;
                    model_q.push_back(it);
                end
            end
        end
    endfunction

    function automatic int item_word();
        return int'({bus.seq_index, bus.seq_gate, bus.first});
    endfunction

    task automatic check_idle_outputs(input string name);
        check({name, "_ready"},      int'(bus.ready),      0);
        check({name, "_first"},      int'(bus.first),      0);
        check({name, "_seq_index"},  int'(bus.seq_index),  0);
        check({name, "_seq_gate"},   int'(bus.seq_gate),   0);
        check({name, "_seq_length"}, int'(bus.seq_length), 0);
        check({name, "_busy"},       int'(bus.busy),       0);
        check({name, "_finished"},   int'(bus.finished),   0);
    endtask

    // fixed_delay < 0 picks a random 0..7 stall per item; halt_at/restart_at are 1-based strobe numbers, <= 0 disables.
    task automatic run_enum(input int fixed_delay, input bit keep_high, input int halt_at,
                            input int restart_at, input string name);
        int    exp_n      = model_q.size();
        int    strobes    = 0;
        int    since      = 0;
        int    d          = 0;
        int    held       = 0;
        bit    ended      = 1'b0;
        bit    prev_ready = 1'b0;
        item_t it;
        if (halt_at > 0) begin
            for (int j = halt_at - 1; j < model_q.size(); j++) begin
                if (model_q[j].idx == 0) begin
                    exp_n = j + 1;
                    break;
                end
            end
        end
        bus.available = 1'b0;
        bus.halt      = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.ready) begin
                strobes++;
                check({name, "_ready_pulse"}, int'(prev_ready), 0);
                if (strobes == 1) check({name, "_finished_cleared"}, int'(bus.finished), 0);
                if (strobes <= exp_n) begin
                    it = model_q[strobes - 1];
                    check({name, "_idx"},   int'(bus.seq_index),  it.idx);
                    check({name, "_gate"},  int'(bus.seq_gate),   it.gate);
                    check({name, "_first"}, int'(bus.first),      it.first);
                    check({name, "_len"},   int'(bus.seq_length), it.len);
                end else begin
                    check({name, "_extra_strobe"}, strobes, exp_n);
                end
                held  = item_word();
                since = 0;
                d     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(7, 0));
                bus.available = keep_high;
                if (strobes == halt_at)    bus.halt  = 1'b1;
                if (strobes == restart_at) bus.start = 1'b1;
            end else if (bus.busy) begin
                since++;
                if (since == 1 || !bus.available) check({name, "_hold"}, item_word(), held);
                bus.available = keep_high || (since > d);
            end else begin
                ended = 1'b1;
            end
            prev_ready = bus.ready;
        end
        check({name, "_terminated"}, int'(ended), 1);
        check({name, "_strobes"},    strobes, exp_n);
        check({name, "_finished"},   int'(bus.finished), (halt_at > 0) ? 0 : 1);
        check({name, "_busy"},       int'(bus.busy), 0);
        bus.halt      = 1'b0;
        bus.available = 1'b0;
        $display("run %s: %0d strobes, finished=%0d", name, strobes, bus.finished);
    endtask

    task automatic reset_in_wait();
        bit seen = 1'b0;
        bus.available = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("rstw_first_strobe", int'(bus.ready), 1);
        repeat (2) @(negedge clk);
        check("rstw_in_wait_busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("rstw_after");
        reset     = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            seen = bus.ready;
        end
        check("rstw_restart_strobe", int'(seen), 1);
        check("rstw_restart_idx",    int'(bus.seq_index), 0);
        check("rstw_restart_gate",   int'(bus.seq_gate),  0);
        check("rstw_restart_first",  int'(bus.first),     1);
        $display("reset-in-wait: restart strobe idx=%0d gate=%0d first=%0d",
                 bus.seq_index, bus.seq_gate, bus.first);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.halt      = 1'b0;
        bus.available = 1'b0;
        build_model();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        run_enum(0,  1'b0, -1, -1, "full");
        run_enum(7,  1'b0, -1,  5, "stall7");
        run_enum(0,  1'b1, -1, -1, "keephigh");
        run_enum(-1, 1'b0, -1, -1, "random");
        run_enum(-1, 1'b0, int'($urandom_range(12, 4)), -1, "halt");
        run_enum(0,  1'b0, -1, -1, "after_halt");
        reset_in_wait();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
